// File: rtl/prof_pkg.sv
// Shared types and default widths for the ap_ctrl_hs transaction profiler.
package prof_pkg;

    localparam int unsigned PROF_CNT_W = 32;
    localparam int unsigned PROF_ID_W  = 16;
    localparam int unsigned DROP_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_DONE_HOLD = 2'd2
    } prof_state_e;

    typedef struct packed {
        logic [PROF_ID_W-1:0]  id;
        logic [PROF_CNT_W-1:0] latency;
        logic [PROF_CNT_W-1:0] interval;
        logic [PROF_CNT_W-1:0] stall;
    } prof_rec_t;

endpackage

// File: rtl/prof_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible whenever empty is low.
module prof_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("prof_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/ap_ctrl_txn_profiler.sv
// Profiles ap_ctrl_hs transactions (latency, start interval, done stall) into a record stream.
module ap_ctrl_txn_profiler
    import prof_pkg::*;
#(
    parameter int unsigned CNT_W = PROF_CNT_W,
    parameter int unsigned ID_W  = PROF_ID_W,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ap_start,
    input  logic                    ap_ready,
    input  logic                    ap_done,
    input  logic                    ap_continue,
    input  logic                    finish,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [ID_W+3*CNT_W-1:0] rec_data,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic                    drained
);

    localparam int unsigned REC_W = ID_W + 3 * CNT_W;

    prof_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   t_start_q, t_start_d;
    logic [CNT_W-1:0]   prev_t_start_q, prev_t_start_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               first_q, first_d;
    logic               started_q, started_d;
    logic               finish_seen_q, finish_seen_d;
    logic               drained_q, drained_d;
    logic               protocol_err_q, protocol_err_d;

    logic               start_fire, accept;
    logic               fifo_pop, fifo_full, fifo_empty, drop_now;
    logic               cur_first;
    logic [CNT_W-1:0]   cur_t_start, cur_prev;
    logic [CNT_W-1:0]   rec_latency, rec_interval, rec_stall;
    logic [REC_W-1:0]   rec_word;

    // Handshake events; a start and a done-accept may coincide in one cycle.
    always_comb begin
        start_fire = (state_q == ST_IDLE) && ap_start && !finish_seen_q;
        accept     = (((state_q == ST_RUN) || start_fire) && ap_done && ap_continue)
                   || ((state_q == ST_DONE_HOLD) && ap_continue);
        fifo_pop   = rec_valid && rec_ready;
        drop_now   = accept && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_fire) begin
                    if (ap_done) begin
                        state_d = ap_continue ? ST_IDLE : ST_DONE_HOLD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (ap_done) begin
                    state_d = ap_continue ? ST_IDLE : ST_DONE_HOLD;
                end
            end
            ST_DONE_HOLD: begin
                if (ap_continue) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Record fields and next values; a same-cycle start uses the current cyc as t_start.
    always_comb begin
        cur_t_start  = start_fire ? cyc_q     : t_start_q;
        cur_prev     = start_fire ? t_start_q : prev_t_start_q;
        cur_first    = start_fire ? !started_q : first_q;
        rec_latency  = cyc_q - cur_t_start;
        rec_interval = cur_first ? '0 : cur_t_start - cur_prev;
        rec_stall    = (state_q == ST_DONE_HOLD) ? stall_q + CNT_W'(1) : '0;
        rec_word     = {id_q, rec_latency, rec_interval, rec_stall};

        cyc_d          = cyc_q + CNT_W'(1);
        t_start_d      = t_start_q;
        prev_t_start_d = prev_t_start_q;
        first_d        = first_q;
        started_d      = started_q;
        stall_d        = stall_q;
        if (start_fire) begin
            t_start_d      = cyc_q;
            prev_t_start_d = t_start_q;
            first_d        = !started_q;
            started_d      = 1'b1;
            stall_d        = '0;
        end
        if (state_q == ST_DONE_HOLD) begin
            stall_d = stall_q + CNT_W'(1);
        end

        id_d   = accept ? id_q + ID_W'(1) : id_q;
        drop_d = drop_q;
        if (drop_now && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end

        finish_seen_d  = finish_seen_q || finish;
        drained_d      = finish_seen_q && (state_q == ST_IDLE) && fifo_empty;
        protocol_err_d = protocol_err_q || ((state_q == ST_IDLE) && ap_ready && !ap_start);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_q          <= '0;
            t_start_q      <= '0;
            prev_t_start_q <= '0;
            stall_q        <= '0;
            id_q           <= '0;
            drop_q         <= '0;
            first_q        <= 1'b0;
            started_q      <= 1'b0;
            finish_seen_q  <= 1'b0;
            drained_q      <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            cyc_q          <= cyc_d;
            t_start_q      <= t_start_d;
            prev_t_start_q <= prev_t_start_d;
            stall_q        <= stall_d;
            id_q           <= id_d;
            drop_q         <= drop_d;
            first_q        <= first_d;
            started_q      <= started_d;
            finish_seen_q  <= finish_seen_d;
            drained_q      <= drained_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    prof_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .din   (rec_word),
        .pop   (fifo_pop),
        .dout  (rec_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rec_valid = !fifo_empty;
    assign drop_cnt  = drop_q;
    assign drained   = drained_q;

`ifndef SYNTHESIS
    // Protocol errors are observable in simulation only.
    cover property (@(posedge clock) protocol_err_q);
`endif

endmodule

// File: tb/tb_ap_ctrl_txn_profiler.sv
// Randomized and directed bench for ap_ctrl_txn_profiler against a transaction-level model.
module tb_ap_ctrl_txn_profiler;

    localparam int CW    = 8;
    localparam int IW    = 8;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset, ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready;
    logic        rec_valid, drained;
    logic [31:0] rec_data;
    logic [15:0] drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    ap_ctrl_txn_profiler #(.CNT_W(CW), .ID_W(IW), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .finish      (finish),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_data    (rec_data),
        .drop_cnt    (drop_cnt),
        .drained     (drained)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    // Transaction-level model: one record per completed transaction, kept in a queue.
    logic [7:0]  m_cyc, m_ts, m_prev_ts, m_stall, m_id;
    logic [15:0] m_drop;
    bit          m_busy, m_hold, m_first, m_have_start, m_fin, m_drained, m_known;
    logic [31:0] m_q[$];

    initial m_known = 0;

    always @(posedge clock) begin
        bit pop, acc, start;
        logic [31:0] r;
        if (reset) begin
            m_cyc = 0; m_ts = 0; m_prev_ts = 0; m_stall = 0; m_id = 0; m_drop = 0;
            m_busy = 0; m_hold = 0; m_first = 0; m_have_start = 0; m_fin = 0; m_drained = 0;
            m_q.delete();
        end else begin
            m_drained = m_fin && !m_busy && (m_q.size() == 0);
            pop   = (m_q.size() != 0) && rec_ready;
            start = !m_busy && ap_start && !m_fin;
            acc   = 0;
            if (start) begin
                m_first      = !m_have_start;
                m_prev_ts    = m_ts;
                m_ts         = m_cyc;
                m_have_start = 1;
                m_busy       = 1;
                m_hold       = 0;
                m_stall      = 0;
            end
            if (m_busy) begin
                if (m_hold) begin
                    m_stall = m_stall + 8'd1;
                    if (ap_continue) acc = 1;
                end else if (ap_done) begin
                    if (ap_continue) acc = 1;
                    else m_hold = 1;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                r = {m_id, 8'(m_cyc - m_ts), (m_first ? 8'd0 : 8'(m_ts - m_prev_ts)), m_stall};
                if (m_q.size() < DEPTH) m_q.push_back(r);
                else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                m_id   = m_id + 8'd1;
                m_busy = 0;
                m_hold = 0;
            end
            if (finish) m_fin = 1;
            m_cyc = m_cyc + 8'd1;
        end
        m_known = 1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (m_known) begin
            check("rec_valid", {31'd0, rec_valid}, {31'd0, m_q.size() != 0});
            check("rec_data", rec_data, (m_q.size() != 0) ? m_q[0] : 32'd0);
            check("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_drop});
            check("drained", {31'd0, drained}, {31'd0, m_drained});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1; ap_start = 0; ap_done = 0; ap_continue = 1; ap_ready = 0;
        finish = 0; rec_ready = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic wait_cyc(input logic [7:0] target);
        int guard = 0;
        while (m_cyc != target && guard < 400) begin
            tick();
            guard++;
        end
        if (m_cyc != target) begin
            n_chk++;
            $display("FAIL wait_cyc: cyc %0d never reached %0d", m_cyc, target);
        end
    endtask

    initial begin
        int thr;
        do_reset();
        check("reset_valid", {31'd0, rec_valid}, 32'd0);
        check("reset_data", rec_data, 32'd0);
        check("reset_drop", {16'd0, drop_cnt}, 32'd0);
        check("reset_drained", {31'd0, drained}, 32'd0);

        // Latency 15, then a second start 20 cycles after the first.
        wait_cyc(8'd10); ap_start = 1; tick();
        ap_ready = 1; tick();
        ap_start = 0; ap_ready = 0;
        wait_cyc(8'd25); ap_done = 1; tick();
        ap_done = 0;
        wait_cyc(8'd30); ap_start = 1; tick();
        ap_ready = 1; tick();
        ap_start = 0; ap_ready = 0;
        wait_cyc(8'd40); ap_done = 1; tick();
        ap_done = 0; tick();
        check("first_record", rec_data, 32'h000F_0000);
        rec_ready = 1; tick(); rec_ready = 0;
        check("second_record", rec_data, 32'h010A_1400);

        // Done held for 4 cycles without continue.
        do_reset();
        ap_start = 1; tick(); ap_start = 0;
        run(2);
        ap_done = 1; ap_continue = 0; run(4);
        ap_continue = 1; tick();
        ap_done = 0;
        check("stall_record", rec_data, 32'h0007_0004);

        // Overflow: 20 records into 16 slots, then push+pop while full.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ap_start = 1; ap_done = 1; tick();
            ap_start = 0; ap_done = 0; tick();
        end
        check("overflow_drop", {16'd0, drop_cnt}, 32'd4);
        check("overflow_head_id", {24'd0, rec_data[31:24]}, 32'd0);
        rec_ready = 1; ap_start = 1; ap_done = 1; tick();
        rec_ready = 0; ap_start = 0; ap_done = 0; tick();
        check("full_pushpop_drop", {16'd0, drop_cnt}, 32'd4);
        rec_ready = 1;
        for (int k = 0; k < 16; k++) begin
            check("drain_valid", {31'd0, rec_valid}, 32'd1);
            check("drain_id", {24'd0, rec_data[31:24]}, (k < 15) ? 32'(k + 1) : 32'd20);
            tick();
        end
        check("drain_empty", {31'd0, rec_valid}, 32'd0);
        rec_ready = 0;

        // Reset in the middle of a transaction leaves no trace.
        do_reset();
        ap_start = 1; tick(); ap_start = 0; run(3);
        do_reset();
        ap_start = 1; tick(); ap_start = 0;
        run(6);
        ap_done = 1; tick(); ap_done = 0;
        check("post_reset_record", rec_data, 32'h0007_0000);
        rec_ready = 1; tick(); rec_ready = 0;
        check("post_reset_single", {31'd0, rec_valid}, 32'd0);

        // Finish during RUN: in-flight record kept, later start ignored.
        do_reset();
        ap_start = 1; tick(); ap_start = 0;
        finish = 1; tick(); finish = 0;
        run(2);
        ap_done = 1; tick(); ap_done = 0;
        check("finish_record", rec_data, 32'h0004_0000);
        ap_start = 1; run(3); ap_start = 0;
        check("finish_only_one", rec_data, 32'h0004_0000);
        check("finish_not_drained", {31'd0, drained}, 32'd0);
        rec_ready = 1; tick(); rec_ready = 0;
        check("finish_empty", {31'd0, rec_valid}, 32'd0);
        check("finish_drained_late", {31'd0, drained}, 32'd0);
        tick();
        check("finish_drained", {31'd0, drained}, 32'd1);

        // Latency measured across counter wrap.
        do_reset();
        wait_cyc(8'd253);
        ap_start = 1; tick(); ap_start = 0;
        run(4);
        ap_done = 1; tick(); ap_done = 0;
        check("wrap_record", rec_data, 32'h0005_0000);

        // Randomized traffic with occasional finish and reset.
        thr = 60;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) thr = $urandom_range(5, 95);
            reset       = ($urandom_range(0, 999) < 4);
            finish      = ($urandom_range(0, 999) < 3);
            ap_start    = ($urandom_range(0, 99) < 35);
            ap_done     = ($urandom_range(0, 99) < 30);
            ap_continue = ($urandom_range(0, 99) < 70);
            ap_ready    = ($urandom_range(0, 99) < 15);
            rec_ready   = ($urandom_range(0, 99) < thr);
            tick();
        end
        reset = 0; finish = 0; ap_start = 0; ap_done = 0; rec_ready = 1;
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
